// File: rtl/reflect_stream_pkg.sv
// ---------------------------------------------------------------------------
// reflect_stream_pkg : mode encodings, width helpers and frame FSM states
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package reflect_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS        = 2'b00,
    MODE_BITREV      = 2'b01,
    MODE_BYTE_BITREV = 2'b10,
    MODE_BYTESWAP    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_e;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int nbw_of(input int data_w);
    return $clog2(data_w / 8) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reflect_stream_xform.sv
// ---------------------------------------------------------------------------
// reflect_xform : masks unused byte lanes then applies the selected reflection
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module reflect_xform
  import reflect_stream_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = nb_of(DATA_W),
  localparam int NBW    = nbw_of(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [NBW-1:0]    nbytes_i,
  input  mode_e             mode_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] bit_rev;
  logic [DATA_W-1:0] byte_rev;
  logic [DATA_W-1:0] byte_bitrev;
  int                pad_bits;

  always_comb begin
    masked      = '0;
    bit_rev     = '0;
    byte_rev    = '0;
    byte_bitrev = '0;
    pad_bits    = (NB - int'(nbytes_i)) * 8;
    data_o      = '0;

    for (int i = 0; i < NB; i++) begin
      if (i < int'(nbytes_i)) masked[i*8 +: 8] = data_i[i*8 +: 8];
    end

    // Whole-word reversals put the valid field at the top; shifting by the
    // unused width right-aligns it and leaves the upper lanes zero.
    for (int b = 0; b < DATA_W; b++) bit_rev[b] = masked[DATA_W-1-b];
    for (int i = 0; i < NB; i++) byte_rev[i*8 +: 8] = masked[(NB-1-i)*8 +: 8];
    for (int i = 0; i < NB; i++) begin
      for (int k = 0; k < 8; k++) byte_bitrev[i*8 + k] = masked[i*8 + 7 - k];
    end

    case (mode_i)
      MODE_PASS:        data_o = masked;
      MODE_BITREV:      data_o = bit_rev >> pad_bits;
      MODE_BYTE_BITREV: data_o = byte_bitrev;
      MODE_BYTESWAP:    data_o = byte_rev >> pad_bits;
      default:          data_o = masked;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reflect_stream.sv
// ---------------------------------------------------------------------------
// reflect_stream : framed bit/byte reflection stream with skid buffering
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module reflect_stream
  import reflect_stream_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int NB     = nb_of(DATA_W),
  localparam int NBW    = nbw_of(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [NBW-1:0]    s_nbytes,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [NBW-1:0]    m_nbytes,
  output logic              m_last,
  output logic              frame_active,
  output logic [CNT_W-1:0]  frame_len,
  output logic              mode_err,
  input  logic              err_clr
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [NBW-1:0]    m_nbytes_q, m_nbytes_d;
  logic              m_last_q, m_last_d;

  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [NBW-1:0]    skid_nbytes_q, skid_nbytes_d;
  logic              skid_last_q, skid_last_d;

  frame_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mode_e             mode_lat_q, mode_lat_d;
  logic [CNT_W-1:0]  frame_len_q, frame_len_d;
  logic              mode_err_q, mode_err_d;

  logic              accept;
  mode_e             mode_in;
  mode_e             eff_mode;
  logic [NBW-1:0]    nbytes_norm;
  logic [DATA_W-1:0] xf_data;

  assign s_ready      = ~skid_valid_q;
  assign accept       = s_valid & s_ready;
  assign mode_in      = mode_e'(mode_i);
  assign eff_mode     = (state_q == ST_IN_FRAME) ? mode_lat_q : mode_in;

  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_nbytes     = m_nbytes_q;
  assign m_last       = m_last_q;
  assign frame_active = (state_q == ST_IN_FRAME);
  assign frame_len    = frame_len_q;
  assign mode_err     = mode_err_q;

  // Only the closing beat of a frame may be partial.
  always_comb begin
    nbytes_norm = s_nbytes;
    if (!s_last || (s_nbytes == '0) || (s_nbytes > NBW'(NB))) nbytes_norm = NBW'(NB);
  end

  reflect_xform #(
    .DATA_W   (DATA_W)
  ) u_xform (
    .data_i   (s_data),
    .nbytes_i (nbytes_norm),
    .mode_i   (eff_mode),
    .data_o   (xf_data)
  );

  always_comb begin
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_nbytes_d    = m_nbytes_q;
    m_last_d      = m_last_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_nbytes_d = skid_nbytes_q;
    skid_last_d   = skid_last_q;

    if (!m_valid_q || m_ready) begin
      if (skid_valid_q) begin
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        m_nbytes_d   = skid_nbytes_q;
        m_last_d     = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d    = 1'b1;
        m_data_d     = xf_data;
        m_nbytes_d   = nbytes_norm;
        m_last_d     = s_last;
      end else begin
        m_valid_d    = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled: park the beat so s_ready never waits on m_ready.
      skid_valid_d  = 1'b1;
      skid_data_d   = xf_data;
      skid_nbytes_d = nbytes_norm;
      skid_last_d   = s_last;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_lat_d  = mode_lat_q;
    frame_len_d = frame_len_q;
    mode_err_d  = mode_err_q;

    if (err_clr) mode_err_d = 1'b0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          mode_lat_d = mode_in;
          cnt_d      = CNT_W'(1);
          if (s_last) frame_len_d = CNT_W'(1);
          else        state_d     = ST_IN_FRAME;
        end
        ST_IN_FRAME: begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (mode_in != mode_lat_q) mode_err_d = 1'b1;
          if (s_last) begin
            frame_len_d = cnt_d;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_nbytes_q    <= '0;
      m_last_q      <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_nbytes_q <= '0;
      skid_last_q   <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mode_lat_q    <= MODE_PASS;
      frame_len_q   <= '0;
      mode_err_q    <= 1'b0;
    end else begin
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_nbytes_q    <= m_nbytes_d;
      m_last_q      <= m_last_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_nbytes_q <= skid_nbytes_d;
      skid_last_q   <= skid_last_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_lat_q    <= mode_lat_d;
      frame_len_q   <= frame_len_d;
      mode_err_q    <= mode_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reflect_stream.sv
// ---------------------------------------------------------------------------
// tb_reflect_stream : directed and random checks of reflect_stream (32-bit)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_reflect_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_i;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic [2:0]  s_nbytes;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [2:0]  m_nbytes;
  logic        frame_active, mode_err, err_clr;
  logic [15:0] frame_len;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  nb;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic        mdl_in_frame = 1'b0;
  logic [1:0]  mdl_lat      = 2'b00;
  int          mdl_cnt      = 0;
  int          mdl_flen     = 0;
  logic        mdl_err      = 1'b0;
  logic        hold_v       = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_nb;
  logic        hold_l;
  logic        chk_sready   = 1'b0;
  logic        prev_s_ready = 1'b1;
  logic        rnd_on;

  always #5 clk = ~clk;

  reflect_stream #(
    .DATA_W       (32),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_nbytes     (s_nbytes),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_nbytes     (m_nbytes),
    .m_last       (m_last),
    .frame_active (frame_active),
    .frame_len    (frame_len),
    .mode_err     (mode_err),
    .err_clr      (err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference transform built from byte/bit lists rather than word shifts.
  function automatic logic [31:0] model_xf(input logic [1:0] md, input logic [31:0] d, input int n);
    logic [7:0]  b [4];
    logic [31:0] v;
    logic [31:0] r;
    v = '0;
    r = '0;
    for (int i = 0; i < 4; i++) b[i] = (i < n) ? d[8*i +: 8] : 8'h00;
    for (int i = 0; i < n; i++) v[8*i +: 8] = b[i];
    case (md)
      2'b00: r = v;
      2'b01: for (int k = 0; k < n*8; k++) r[n*8-1-k] = v[k];
      2'b10: for (int i = 0; i < n; i++) for (int k = 0; k < 8; k++) r[8*i+k] = b[i][7-k];
      default: for (int j = 0; j < n; j++) r[8*j +: 8] = b[n-1-j];
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_in_frame = 1'b0;
      mdl_lat      = 2'b00;
      mdl_cnt      = 0;
      mdl_flen     = 0;
      mdl_err      = 1'b0;
      hold_v       = 1'b0;
      prev_s_ready = 1'b1;
    end else begin
      chk("frame_active", 64'(frame_active), 64'(mdl_in_frame));
      chk("frame_len", 64'(frame_len), 64'(mdl_flen));
      chk("mode_err", 64'(mode_err), 64'(mdl_err));
      if (hold_v) begin
        chk("stall_data", 64'(m_data), 64'(hold_d));
        chk("stall_nbytes", 64'(m_nbytes), 64'(hold_nb));
        chk("stall_last", 64'(m_last), 64'(hold_l));
        chk("stall_valid", 64'(m_valid), 64'(1));
      end
      if (chk_sready) chk("s_ready_low_twice", 64'(s_ready | prev_s_ready), 64'(1));
      prev_s_ready = s_ready;

      if (m_valid && m_ready) begin
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL extra_beat: observed data=%0h expected no beat", m_data);
        end
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", 64'(m_data), 64'(e.d));
          chk("out_nbytes", 64'(m_nbytes), 64'(e.nb));
          chk("out_last", 64'(m_last), 64'(e.l));
        end
      end
      hold_v  = m_valid && !m_ready;
      hold_d  = m_data;
      hold_nb = m_nbytes;
      hold_l  = m_last;

      if (s_valid && s_ready) begin
        beat_t      nb_beat;
        int         n;
        logic [1:0] md;
        logic       set_err;
        n = (!s_last || s_nbytes == 3'd0 || s_nbytes > 3'd4) ? 4 : int'(s_nbytes);
        md = mdl_in_frame ? mdl_lat : mode_i;
        nb_beat.d  = model_xf(md, s_data, n);
        nb_beat.nb = 3'(n);
        nb_beat.l  = s_last;
        exp_q.push_back(nb_beat);
        set_err = mdl_in_frame && (mode_i != mdl_lat);
        if (!mdl_in_frame) begin
          mdl_lat = mode_i;
          mdl_cnt = 1;
          if (s_last) mdl_flen = 1;
          else        mdl_in_frame = 1'b1;
        end else begin
          if (mdl_cnt < 65535) mdl_cnt++;
          if (s_last) begin
            mdl_flen     = mdl_cnt;
            mdl_in_frame = 1'b0;
          end
        end
        if (set_err)      mdl_err = 1'b1;
        else if (err_clr) mdl_err = 1'b0;
      end else if (err_clr) begin
        mdl_err = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [1:0] md, input logic [31:0] d, input logic [2:0] nb, input logic lst);
    logic done;
    done     = 1'b0;
    mode_i   = md;
    s_data   = d;
    s_nbytes = nb;
    s_last   = lst;
    s_valid  = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'(done), 64'(1));
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; mode_i = 2'b00; s_valid = 1'b0; s_data = '0; s_nbytes = '0;
    s_last = 1'b0; m_ready = 1'b1; err_clr = 1'b0; rnd_on = 1'b0;
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_nbytes", 64'(m_nbytes), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_frame_len", 64'(frame_len), 64'(0));
    chk("rst_mode_err", 64'(mode_err), 64'(0));
    chk("rst_frame_active", 64'(frame_active), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);

    // Single-beat frames with hand-computed results.
    send_beat(2'b01, 32'h0000_0001, 3'd4, 1'b1); s_valid = 1'b0;
    chk("bitrev_data", 64'(m_data), 64'h8000_0000);
    chk("bitrev_nbytes", 64'(m_nbytes), 64'd4);
    chk("bitrev_flen", 64'(frame_len), 64'd1);
    send_beat(2'b10, 32'h0102_0380, 3'd4, 1'b1); s_valid = 1'b0;
    chk("bytebitrev_data", 64'(m_data), 64'h8040_C001);
    send_beat(2'b11, 32'h1122_3344, 3'd4, 1'b1); s_valid = 1'b0;
    chk("byteswap_data", 64'(m_data), 64'h4433_2211);
    send_beat(2'b01, 32'hFFFF_0001, 3'd2, 1'b1); s_valid = 1'b0;
    chk("partial_bitrev_data", 64'(m_data), 64'h0000_8000);
    chk("partial_bitrev_nbytes", 64'(m_nbytes), 64'd2);
    send_beat(2'b11, 32'hAA11_2233, 3'd3, 1'b1); s_valid = 1'b0;
    chk("partial_swap_data", 64'(m_data), 64'h0033_2211);
    send_beat(2'b00, 32'hDEAD_BEEF, 3'd0, 1'b1); s_valid = 1'b0;
    chk("nbytes0_pass_nbytes", 64'(m_nbytes), 64'd4);
    cycles(2);

    // Five-beat frame against a toggling sink.
    chk_sready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(2'b01, 32'h100 + 32'(i), 3'd1, 1'(i == 4));
        s_valid = 1'b0;
      end
      begin
        repeat (12) begin
          @(posedge clk); #1;
          m_ready = ~m_ready;
        end
      end
    join
    chk_sready = 1'b0;
    m_ready = 1'b1;
    cycles(4);
    chk("toggle_drained", 64'(exp_q.size()), 64'd0);
    chk("toggle_flen", 64'(frame_len), 64'd5);

    // Mode change mid-frame keeps the latched mode and flags an error.
    send_beat(2'b01, 32'h1, 3'd4, 1'b0);
    send_beat(2'b01, 32'h2, 3'd4, 1'b0);
    send_beat(2'b11, 32'h3, 3'd4, 1'b0);
    send_beat(2'b11, 32'h4, 3'd4, 1'b1); s_valid = 1'b0;
    chk("moderr_last_data", 64'(m_data), 64'h2000_0000);
    chk("moderr_set", 64'(mode_err), 64'd1);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    chk("moderr_clear", 64'(mode_err), 64'd0);
    send_beat(2'b01, 32'h5, 3'd4, 1'b0);
    err_clr = 1'b1;
    send_beat(2'b10, 32'h6, 3'd4, 1'b1); s_valid = 1'b0; err_clr = 1'b0;
    chk("moderr_set_wins", 64'(mode_err), 64'd1);
    err_clr = 1'b1; cycles(1); err_clr = 1'b0;
    cycles(2);

    // Reset in the middle of a stalled frame.
    m_ready = 1'b0;
    send_beat(2'b01, 32'hA, 3'd4, 1'b0);
    send_beat(2'b01, 32'hB, 3'd4, 1'b0);
    s_valid = 1'b0;
    chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_frame_active", 64'(frame_active), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
    chk("mid_rst_m_data", 64'(m_data), 64'd0);
    cycles(2);
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("post_rst_no_beat", 64'(m_valid), 64'd0);
    end
    send_beat(2'b00, 32'hC, 3'd4, 1'b0);
    send_beat(2'b00, 32'hD, 3'd4, 1'b1); s_valid = 1'b0;
    chk("post_rst_flen", 64'(frame_len), 64'd2);
    cycles(2);

    // Random frames against a random sink.
    rnd_on = 1'b1;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          logic [1:0] fm;
          int         len;
          fm  = 2'($urandom_range(0, 3));
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            logic [1:0] bm;
            bm = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : fm;
            err_clr = ($urandom_range(0, 15) == 0);
            send_beat(bm, $urandom, 3'($urandom_range(0, 7)), 1'(b == len - 1));
            if ($urandom_range(0, 3) == 0) begin
              s_valid = 1'b0;
              cycles(1);
            end
          end
        end
        s_valid = 1'b0;
        err_clr = 1'b0;
        rnd_on  = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    cycles(5);
    chk("random_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reflect_stream.md
REFLECT_STREAM -- requirements
Module: reflect_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter CNT_W, default 16: width of the frame beat counter.
REQ-003 SHALL use derived constants NB = DATA_W/8 and NBW = clog2(NB)+1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port mode_i, input, 2: transform select; 00 pass, 01 full bit reverse, 10 bit reverse within each byte, 11 byte swap.
REQ-007 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, DATA_W), s_nbytes (input, NBW) and s_last (input, 1): the input stream.
REQ-008 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, DATA_W), m_nbytes (output, NBW) and m_last (output, 1): the output stream.
REQ-009 SHALL have ports frame_active (output, 1) and frame_len (output, CNT_W): frame_len is the beat count of the last completed frame.
REQ-010 SHALL have ports mode_err (output, 1), a sticky error flag, and err_clr (input, 1), which clears it.

Function
REQ-011 SHALL transfer a beat on each channel only when valid and ready are both high on the same edge.
REQ-012 SHALL hold m_data, m_nbytes and m_last stable while m_valid=1 and m_ready=0.
REQ-013 SHALL present an accepted beat on m_* one cycle after acceptance when the output is empty or draining; latency is 1 cycle.
REQ-014 SHALL sustain one beat per cycle using a 2-entry buffer (output register plus skid register).
REQ-015 SHALL drive s_ready=0 only while the skid register is occupied; s_ready SHALL NOT depend combinationally on m_ready.
REQ-016 SHALL treat s_nbytes=0 or s_nbytes>NB as NB, and SHALL treat s_nbytes as NB on any beat with s_last=0.
REQ-017 SHALL force byte lanes at index >= nbytes to zero before the transform; valid bytes occupy the low lanes.
REQ-018 SHALL, in mode 01, reverse the low nbytes*8 bits as one field, right-aligned in the result, with upper lanes zero.
REQ-019 SHALL, in mode 10, reverse the bit order inside each valid byte independently.
REQ-020 SHALL, in mode 11, reverse the order of the low nbytes bytes, right-aligned in the result, with upper lanes zero.
REQ-021 SHALL, in mode 00, output the masked data unchanged.
REQ-022 SHALL set m_nbytes to the normalised nbytes and pass m_last through from the input beat.
REQ-023 SHALL implement a frame FSM with states IDLE and IN_FRAME.
REQ-024 SHALL, in IDLE, on an accepted beat: latch mode_i and set the beat counter to 1; go to IN_FRAME if s_last=0, otherwise stay in IDLE and complete the frame.
REQ-025 SHALL, in IN_FRAME, on each accepted beat: increment the counter, saturating at all-ones; on s_last=1, complete the frame and return to IDLE.
REQ-026 SHALL apply the latched mode to every beat of the frame; the first beat SHALL use mode_i directly.
REQ-027 SHALL, on frame completion, load frame_len with the final count on the same edge.
REQ-028 SHALL drive frame_active=1 exactly while in state IN_FRAME.
REQ-029 SHALL set mode_err when a beat is accepted in IN_FRAME with mode_i not equal to the latched mode.
REQ-030 SHALL clear mode_err on err_clr=1; if set and clear occur on the same edge, set SHALL win.

Reset
REQ-031 SHALL, on rst=1 and independent of clk: set m_valid=0 and s_ready=1 and empty the skid register.
REQ-032 SHALL, on rst=1: set m_data=0, m_nbytes=0, m_last=0, frame_len=0, mode_err=0 and frame_active=0; FSM to IDLE; counter to 0; latched mode to 00.
REQ-033 SHALL discard any in-flight beats and any partial frame on reset mid-frame, with no output beat after reset release until a new acceptance.

Structure
REQ-034 SHALL take the mode encodings, the NB/NBW derivations and an FSM state typedef from the shared package used by the CRC peripheral.
REQ-035 SHALL contain one combinational sub-module, reflect_xform (mask, nbytes and mode in, transformed word out), instantiated once on the input path.

Verification (DATA_W=32)
REQ-036 SHALL check: mode 01, single last beat 0x00000001, nbytes 4 -> m_data 0x80000000, frame_len 1.
REQ-037 SHALL check: mode 10, beat 0x01020380 -> 0x8040C001; mode 11, beat 0x11223344 -> 0x44332211.
REQ-038 SHALL check partial last beats: mode 01, 0xFFFF0001 with nbytes 2 -> 0x00008000 with m_nbytes 2; mode 11, 0xAA112233 with nbytes 3 -> 0x00332211.
REQ-039 SHALL check: a 5-beat frame with s_valid held high and m_ready toggling 1,0,1,0 -> no beat lost or duplicated, outputs stable while stalled, s_ready never low two consecutive cycles, frame_len 5.
REQ-040 SHALL check: mode_i changed 01->11 on beat 3 of a frame -> all beats transformed with 01, mode_err=1; err_clr then clears it; set and clear on the same edge -> stays 1.
REQ-041 SHALL check: rst asserted mid-frame with m_valid=1 -> m_valid=0 and frame_active=0 immediately; the next frame's frame_len counts from 1.
